// File: rtl/i2c_config_seq.sv
// LUT-driven I2C register-configuration sequencer: walks a register table and
// issues write (and optional read-back verify) requests to an external I2C master.
module i2c_config_seq #(
  parameter int unsigned LUT_AW     = 10,
  parameter int unsigned LUT_LAT    = 1,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned DELAY_UNIT = 50000,
  parameter int unsigned AUTO_START = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              verify_en,
  output logic [LUT_AW-1:0] lut_index,
  input  logic [7:0]        lut_dev_addr,
  input  logic [15:0]       lut_reg_addr,
  input  logic [7:0]        lut_reg_data,
  output logic              i2c_write_req,
  input  logic              i2c_write_req_ack,
  output logic              i2c_read_req,
  input  logic              i2c_read_req_ack,
  input  logic              i2c_err,
  input  logic [7:0]        i2c_read_data,
  output logic [7:0]        i2c_slave_dev_addr,
  output logic [15:0]       i2c_slave_reg_addr,
  output logic [7:0]        i2c_write_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LUT_AW-1:0] err_index,
  output logic [LUT_AW-1:0] err_count
);

  localparam int unsigned DW         = $clog2(64'd65535 * 64'(DELAY_UNIT) + 64'd1);
  localparam int unsigned FETCH_LAST = (LUT_LAT == 0) ? 0 : LUT_LAT - 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_CHECK, S_WRITE, S_READ, S_FAIL, S_DELAY, S_NEXT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LUT_AW-1:0] lut_index_q, lut_index_d;
  logic [7:0]        dev_q, dev_d;
  logic [15:0]       reg_q, reg_d;
  logic [7:0]        data_q, data_d;
  logic              wr_req_q, wr_req_d;
  logic              rd_req_q, rd_req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [LUT_AW-1:0] err_index_q, err_index_d;
  logic [LUT_AW-1:0] err_count_q, err_count_d;
  logic [3:0]        retry_q, retry_d;
  logic [3:0]        fetch_cnt_q, fetch_cnt_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic              verify_q, verify_d;
  logic              auto_q, auto_d;

  always_comb begin
    state_d     = state_q;
    lut_index_d = lut_index_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    data_d      = data_q;
    wr_req_d    = wr_req_q;
    rd_req_d    = rd_req_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    err_index_d = err_index_q;
    err_count_d = err_count_q;
    retry_d     = retry_q;
    fetch_cnt_d = fetch_cnt_q;
    dly_d       = dly_q;
    verify_d    = verify_q;
    auto_d      = auto_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // auto_q can only be set in IDLE, so DONE effectively restarts on start alone
        if (start || auto_q) begin
          auto_d      = 1'b0;
          lut_index_d = '0;
          error_d     = 1'b0;
          err_index_d = '0;
          err_count_d = '0;
          retry_d     = '0;
          fetch_cnt_d = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        if (fetch_cnt_q == 4'(FETCH_LAST)) begin
          fetch_cnt_d = '0;
          state_d     = S_CHECK;
        end else begin
          fetch_cnt_d = fetch_cnt_q + 4'd1;
        end
      end
      S_CHECK: begin
        verify_d = verify_en;
        if (lut_dev_addr == 8'hFF) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (lut_dev_addr == 8'hFE) begin
          dly_d   = DW'(64'(lut_reg_addr) * 64'(DELAY_UNIT));
          state_d = (lut_reg_addr == 16'd0) ? S_NEXT : S_DELAY;
        end else begin
          dev_d    = lut_dev_addr;
          reg_d    = lut_reg_addr;
          data_d   = lut_reg_data;
          wr_req_d = 1'b1;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wr_req_q && i2c_write_req_ack) begin
          wr_req_d = 1'b0;
          if (i2c_err) begin
            state_d = S_FAIL;
          end else if (verify_q) begin
            rd_req_d = 1'b1;
            state_d  = S_READ;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_READ: begin
        if (rd_req_q && i2c_read_req_ack) begin
          rd_req_d = 1'b0;
          state_d  = (i2c_err || (i2c_read_data != data_q)) ? S_FAIL : S_NEXT;
        end
      end
      S_FAIL: begin
        if (retry_q < 4'(MAX_RETRY)) begin
          retry_d  = retry_q + 4'd1;
          wr_req_d = 1'b1;
          state_d  = S_WRITE;
        end else begin
          error_d = 1'b1;
          if (!error_q) err_index_d = lut_index_q;
          if (err_count_q != '1) err_count_d = err_count_q + LUT_AW'(1);
          state_d = S_NEXT;
        end
      end
      S_DELAY: begin
        if (dly_q == '0) state_d = S_NEXT;
        else             dly_d   = dly_q - DW'(1);
      end
      S_NEXT: begin
        retry_d = '0;
        if (lut_index_q == '1) begin
          error_d     = 1'b1;
          err_index_d = lut_index_q;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end else begin
          lut_index_d = lut_index_q + LUT_AW'(1);
          state_d     = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lut_index_q <= '0;
      dev_q       <= '0;
      reg_q       <= '0;
      data_q      <= '0;
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
      err_count_q <= '0;
      retry_q     <= '0;
      fetch_cnt_q <= '0;
      dly_q       <= '0;
      verify_q    <= 1'b0;
      auto_q      <= 1'(AUTO_START);
    end else begin
      state_q     <= state_d;
      lut_index_q <= lut_index_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      data_q      <= data_d;
      wr_req_q    <= wr_req_d;
      rd_req_q    <= rd_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
      err_count_q <= err_count_d;
      retry_q     <= retry_d;
      fetch_cnt_q <= fetch_cnt_d;
      dly_q       <= dly_d;
      verify_q    <= verify_d;
      auto_q      <= auto_d;
    end
  end

  assign lut_index          = lut_index_q;
  assign i2c_write_req      = wr_req_q;
  assign i2c_read_req       = rd_req_q;
  assign i2c_slave_dev_addr = dev_q;
  assign i2c_slave_reg_addr = reg_q;
  assign i2c_write_data     = data_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign error              = error_q;
  assign err_index          = err_index_q;
  assign err_count          = err_count_q;

endmodule

// File: tb/tb_i2c_config_seq.sv
// Directed bench for i2c_config_seq: registered LUT ROM plus a simple I2C master
// model with programmable NACK and read-back corruption.
module tb_i2c_config_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        verify_en = 1'b0;
  logic [2:0]  lut_index;
  logic [7:0]  lut_dev_addr;
  logic [15:0] lut_reg_addr;
  logic [7:0]  lut_reg_data;
  logic        i2c_write_req;
  logic        i2c_write_req_ack = 1'b0;
  logic        i2c_read_req;
  logic        i2c_read_req_ack = 1'b0;
  logic        i2c_err = 1'b0;
  logic [7:0]  i2c_read_data = 8'h00;
  logic [7:0]  i2c_slave_dev_addr;
  logic [15:0] i2c_slave_reg_addr;
  logic [7:0]  i2c_write_data;
  logic        busy, done, error;
  logic [2:0]  err_index, err_count;

  i2c_config_seq #(
    .LUT_AW(3), .LUT_LAT(1), .MAX_RETRY(2), .DELAY_UNIT(10), .AUTO_START(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .verify_en(verify_en),
    .lut_index(lut_index), .lut_dev_addr(lut_dev_addr), .lut_reg_addr(lut_reg_addr),
    .lut_reg_data(lut_reg_data), .i2c_write_req(i2c_write_req),
    .i2c_write_req_ack(i2c_write_req_ack), .i2c_read_req(i2c_read_req),
    .i2c_read_req_ack(i2c_read_req_ack), .i2c_err(i2c_err), .i2c_read_data(i2c_read_data),
    .i2c_slave_dev_addr(i2c_slave_dev_addr), .i2c_slave_reg_addr(i2c_slave_reg_addr),
    .i2c_write_data(i2c_write_data), .busy(busy), .done(done), .error(error),
    .err_index(err_index), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  dev_m [8];
  logic [15:0] reg_m [8];
  logic [7:0]  dat_m [8];
  always @(posedge clk) begin
    lut_dev_addr <= dev_m[lut_index];
    lut_reg_addr <= reg_m[lut_index];
    lut_reg_data <= dat_m[lut_index];
  end

  // Master model controls, written only by the stimulus process.
  int ack_lat = 20;
  int err_entry = -1;
  int err_quota = 0;
  int bad_rd_entry = -1;
  logic stray_ack = 1'b0;

  // Master model state and transaction log, written only by the model process.
  int n_wr = 0, n_rd = 0, err_used = 0, both_high = 0;
  int wr_cnt = 0, rd_cnt = 0;
  logic prev_wr = 1'b0;
  logic [7:0]  log_dev [128];
  logic [15:0] log_reg [128];
  logic [7:0]  log_dat [128];
  int          log_idx [128];
  int          log_rise[128];
  int          log_ack [128];

  always @(negedge clk) begin
    i2c_write_req_ack = 1'b0;
    i2c_read_req_ack  = 1'b0;
    i2c_err           = 1'b0;
    if (!rst_n) begin
      wr_cnt = 0; rd_cnt = 0; prev_wr = 1'b0;
    end else begin
      if (i2c_write_req && i2c_read_req) both_high++;
      if (i2c_write_req && !prev_wr && n_wr < 128) begin
        log_dev[n_wr]  = i2c_slave_dev_addr;
        log_reg[n_wr]  = i2c_slave_reg_addr;
        log_dat[n_wr]  = i2c_write_data;
        log_idx[n_wr]  = int'(lut_index);
        log_rise[n_wr] = cyc;
        n_wr++;
      end
      prev_wr = i2c_write_req;
      if (i2c_write_req) begin
        wr_cnt++;
        if (wr_cnt >= ack_lat) begin
          wr_cnt = 0;
          i2c_write_req_ack = 1'b1;
          if (n_wr > 0) log_ack[n_wr-1] = cyc;
          if (int'(lut_index) == err_entry && err_used < err_quota) begin
            i2c_err = 1'b1;
            err_used++;
          end
        end
      end else wr_cnt = 0;
      if (i2c_read_req) begin
        rd_cnt++;
        if (rd_cnt >= ack_lat) begin
          rd_cnt = 0;
          i2c_read_req_ack = 1'b1;
          n_rd++;
          i2c_read_data = (int'(lut_index) == bad_rd_entry) ? i2c_write_data + 8'd1 : i2c_write_data;
        end
      end else rd_cnt = 0;
      if (stray_ack) begin
        i2c_write_req_ack = 1'b1;
        i2c_read_req_ack  = 1'b1;
      end
    end
  end

  task automatic clear_lut();
    for (int i = 0; i < 8; i++) begin
      dev_m[i] = 8'hFF; reg_m[i] = 16'h0000; dat_m[i] = 8'h00;
    end
  endtask

  task automatic load_lut1();
    clear_lut();
    dev_m[0] = 8'h78; reg_m[0] = 16'h3008; dat_m[0] = 8'h02;
    dev_m[1] = 8'h78; reg_m[1] = 16'h3103; dat_m[1] = 8'h11;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    load_lut1();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (i2c_write_req !== 1'b0) begin failures++; $display("FAIL reset_wr_req got %b exp 0", i2c_write_req); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL reset_flags got %b%b%b exp 000", busy, done, error); end
    checks++; if (lut_index !== 3'd0 || err_index !== 3'd0 || err_count !== 3'd0) begin failures++; $display("FAIL reset_idx got %0d/%0d/%0d exp 0/0/0", lut_index, err_index, err_count); end
    checks++; if (i2c_slave_dev_addr !== 8'h00 || i2c_slave_reg_addr !== 16'h0000 || i2c_write_data !== 8'h00) begin failures++; $display("FAIL reset_slave got %h/%h/%h exp 0", i2c_slave_dev_addr, i2c_slave_reg_addr, i2c_write_data); end
  endtask

  task automatic test_basic_auto();
    bit ok;
    int base = n_wr;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL auto_start_busy got %b exp 1", busy); end
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got 0 exp 1"); end
    checks++; if (n_wr - base != 2) begin failures++; $display("FAIL basic_nwr got %0d exp 2", n_wr - base); end
    checks++; if (log_dev[base] !== 8'h78 || log_reg[base] !== 16'h3008 || log_dat[base] !== 8'h02) begin failures++; $display("FAIL basic_w0 got %h/%h/%h exp 78/3008/02", log_dev[base], log_reg[base], log_dat[base]); end
    checks++; if (log_dev[base+1] !== 8'h78 || log_reg[base+1] !== 16'h3103 || log_dat[base+1] !== 8'h11) begin failures++; $display("FAIL basic_w1 got %h/%h/%h exp 78/3103/11", log_dev[base+1], log_reg[base+1], log_dat[base+1]); end
    checks++; if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0 || lut_index !== 3'd2) begin failures++; $display("FAIL basic_final got d%b e%b b%b idx%0d exp d1 e0 b0 idx2", done, error, busy, lut_index); end
  endtask

  task automatic test_delay();
    bit ok;
    int base = n_wr;
    int gap;
    clear_lut();
    dev_m[0] = 8'h78; reg_m[0] = 16'h3008; dat_m[0] = 8'h02;
    dev_m[1] = 8'hFE; reg_m[1] = 16'h0003;
    dev_m[2] = 8'h78; reg_m[2] = 16'h3103; dat_m[2] = 8'h11;
    pulse_start();
    wait_done(ok);
    gap = log_rise[base+1] - log_ack[base];
    checks++; if (!ok || n_wr - base != 2) begin failures++; $display("FAIL delay_nwr got %0d ok %0d exp 2", n_wr - base, ok); end
    checks++; if (gap < 30 || gap > 50) begin failures++; $display("FAIL delay_gap got %0d exp 30..50", gap); end
    checks++; if (lut_index !== 3'd3 || error !== 1'b0) begin failures++; $display("FAIL delay_final got idx%0d e%b exp idx3 e0", lut_index, error); end
  endtask

  task automatic test_verify_pass();
    bit ok;
    int bw = n_wr, br = n_rd;
    clear_lut();
    dev_m[0] = 8'h3C; reg_m[0] = 16'h0010; dat_m[0] = 8'h11;
    verify_en = 1'b1;
    pulse_start();
    wait_done(ok);
    checks++; if (!ok || n_wr - bw != 1 || n_rd - br != 1) begin failures++; $display("FAIL verify_pass_counts got w%0d r%0d exp w1 r1", n_wr - bw, n_rd - br); end
    checks++; if (error !== 1'b0 || err_count !== 3'd0) begin failures++; $display("FAIL verify_pass_err got e%b c%0d exp e0 c0", error, err_count); end
  endtask

  task automatic test_verify_retry();
    bit ok;
    int bw = n_wr, br = n_rd;
    load_lut1();
    verify_en = 1'b1;
    bad_rd_entry = 1;
    pulse_start();
    wait_done(ok);
    checks++; if (!ok || n_wr - bw != 4 || n_rd - br != 4) begin failures++; $display("FAIL verify_retry_counts got w%0d r%0d exp w4 r4", n_wr - bw, n_rd - br); end
    checks++; if (log_idx[bw+3] != 1 || log_dat[bw+3] !== 8'h11) begin failures++; $display("FAIL verify_retry_last got idx%0d d%h exp idx1 d11", log_idx[bw+3], log_dat[bw+3]); end
    checks++; if (error !== 1'b1 || err_index !== 3'd1 || err_count !== 3'd1) begin failures++; $display("FAIL verify_retry_err got e%b i%0d c%0d exp e1 i1 c1", error, err_index, err_count); end
    checks++; if (done !== 1'b1 || lut_index !== 3'd2) begin failures++; $display("FAIL verify_retry_end got d%b idx%0d exp d1 idx2", done, lut_index); end
    bad_rd_entry = -1;
    verify_en = 1'b0;
  endtask

  task automatic test_nack_retry();
    bit ok;
    int bw = n_wr;
    load_lut1();
    err_entry = 0;
    err_quota = err_used + 1;
    pulse_start();
    wait_done(ok);
    checks++; if (!ok || n_wr - bw != 3) begin failures++; $display("FAIL nack_nwr got %0d exp 3", n_wr - bw); end
    checks++; if (log_idx[bw] != 0 || log_idx[bw+1] != 0 || log_idx[bw+2] != 1) begin failures++; $display("FAIL nack_order got %0d,%0d,%0d exp 0,0,1", log_idx[bw], log_idx[bw+1], log_idx[bw+2]); end
    checks++; if (error !== 1'b0 || err_count !== 3'd0) begin failures++; $display("FAIL nack_err got e%b c%0d exp e0 c0", error, err_count); end
    err_entry = -1;
  endtask

  task automatic test_start_ignored();
    bit ok;
    int bw = n_wr;
    load_lut1();
    pulse_start();
    for (int i = 0; i < 200 && n_wr == bw; i++) @(negedge clk);
    repeat (25) @(negedge clk);
    pulse_start();
    wait_done(ok);
    checks++; if (!ok || n_wr - bw != 2) begin failures++; $display("FAIL start_busy_nwr got %0d exp 2", n_wr - bw); end
    checks++; if (log_reg[bw+1] !== 16'h3103 || lut_index !== 3'd2) begin failures++; $display("FAIL start_busy_seq got %h idx%0d exp 3103 idx2", log_reg[bw+1], lut_index); end
  endtask

  task automatic test_stray_ack();
    int bw = n_wr;
    @(negedge clk); stray_ack = 1'b1;
    @(negedge clk); stray_ack = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || n_wr != bw || i2c_read_req !== 1'b0) begin failures++; $display("FAIL stray_ack got d%b b%b w%0d exp d1 b0 w0", done, busy, n_wr - bw); end
  endtask

  task automatic test_overflow();
    bit ok;
    int bw = n_wr;
    for (int i = 0; i < 8; i++) begin
      dev_m[i] = 8'h50; reg_m[i] = 16'(i); dat_m[i] = 8'(i + 16);
    end
    pulse_start();
    wait_done(ok);
    checks++; if (!ok || n_wr - bw != 8) begin failures++; $display("FAIL overflow_nwr got %0d exp 8", n_wr - bw); end
    checks++; if (error !== 1'b1 || err_index !== 3'd7 || err_count !== 3'd0) begin failures++; $display("FAIL overflow_err got e%b i%0d c%0d exp e1 i7 c0", error, err_index, err_count); end
    checks++; if (log_reg[bw+7] !== 16'h0007 || log_dat[bw+7] !== 8'h17) begin failures++; $display("FAIL overflow_last got %h/%h exp 0007/17", log_reg[bw+7], log_dat[bw+7]); end
  endtask

  task automatic test_restart_clears();
    bit ok;
    load_lut1();
    pulse_start();
    checks++; if (error !== 1'b0 || err_index !== 3'd0 || busy !== 1'b1 || done !== 1'b0 || lut_index !== 3'd0) begin failures++; $display("FAIL restart_clear got e%b i%0d b%b d%b idx%0d exp e0 i0 b1 d0 idx0", error, err_index, busy, done, lut_index); end
    wait_done(ok);
    checks++; if (!ok || error !== 1'b0 || lut_index !== 3'd2) begin failures++; $display("FAIL restart_run got ok%0d e%b idx%0d exp ok1 e0 idx2", ok, error, lut_index); end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    int bw;
    load_lut1();
    pulse_start();
    for (int i = 0; i < 200 && !i2c_write_req; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (i2c_write_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_req got r%b b%b exp r0 b0", i2c_write_req, busy); end
    checks++; if (i2c_slave_dev_addr !== 8'h00 || i2c_write_data !== 8'h00 || lut_index !== 3'd0) begin failures++; $display("FAIL rst_mid_out got %h/%h idx%0d exp 00/00 idx0", i2c_slave_dev_addr, i2c_write_data, lut_index); end
    repeat (2) @(negedge clk);
    bw = n_wr;
    rst_n = 1'b1;
    wait_done(ok);
    checks++; if (!ok || n_wr - bw != 2 || error !== 1'b0) begin failures++; $display("FAIL rst_mid_rerun got w%0d e%b exp w2 e0", n_wr - bw, error); end
    checks++; if (both_high != 0) begin failures++; $display("FAIL req_exclusive got %0d exp 0", both_high); end
  endtask

  initial begin
    test_reset();
    test_basic_auto();
    test_delay();
    test_verify_pass();
    test_verify_retry();
    test_nack_retry();
    test_start_ignored();
    test_stray_ack();
    test_overflow();
    test_restart_clears();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
